exception_unit: RTL and testbench

- Parametrised exception/interrupt controller for the multicycle MIPS datapath.
- Generalises the fixed two-cause EPC/Cause/treatment-address logic to N prioritised, maskable causes.
- Each cause fetches its handler address from a memory-resident vector table, and the unit redirects the PC.
- Sits beside the control unit, shares the memory port through the IorD mux, and drives the PC mux and PC write enable.

---
 rtl/mips_exc_pkg.sv | 20 ++
 rtl/exc_prio_enc.sv | 19 +
 rtl/exception_unit.sv | 127 ++++++++++++
 tb/tb_exception_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_exc_pkg.sv
// Shared types for the exception unit: FSM state encoding and the default cause numbering
// used by the multicycle datapath.
package mips_exc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    HANDLER,
    RETURN
  } exc_state_t;

  localparam int CAUSE_OVERFLOW   = 0;
  localparam int CAUSE_INVALID_OP = 1;

  // Vector fetches stall for at most MEM_LAT-1 <= 3 extra cycles.
  localparam int CNT_W = 2;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: lowest set bit wins, valid when any bit is set.
module exc_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Prioritised, maskable exception controller: latches causes, fetches the handler vector
// through the shared memory port, redirects the PC and restores EPC on eret.
module exception_unit
  import mips_exc_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              N_CAUSES = 4,
  parameter logic [DATA_W-1:0] VEC_BASE = DATA_W'(32'h000000F0),
  parameter int              MEM_LAT  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CAUSES-1:0] cause_req,
  input  logic [DATA_W-1:0]   epc_in,
  input  logic                mask_we,
  input  logic [N_CAUSES-1:0] mask_in,
  input  logic                eret,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                busy,
  output logic                mem_req,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                pc_load,
  output logic [DATA_W-1:0]   pc_value,
  output logic [DATA_W-1:0]   epc,
  output logic [DATA_W-1:0]   cause,
  output logic                exl,
  output logic [N_CAUSES-1:0] mask
);

  localparam int IDX_W = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1;

  exc_state_t          state;
  logic [N_CAUSES-1:0] pending;
  logic [N_CAUSES-1:0] clr;
  logic [IDX_W-1:0]    sel;
  logic                valid;
  logic                accept;
  logic [CNT_W-1:0]    cnt;

  exc_prio_enc #(
    .N     (N_CAUSES),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (pending & ~mask),
    .idx   (sel),
    .valid (valid)
  );

  assign accept = (state == IDLE) && valid && !exl;
  assign clr    = accept ? (N_CAUSES'(1) << sel) : '0;

  // The vector word arrives on mem_data during LOAD, so it bypasses straight to the PC mux.
  always_comb begin
    pc_value = '0;
    if (state == LOAD)        pc_value = mem_data;
    else if (state == RETURN) pc_value = epc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= '0;
      mask     <= '0;
      epc      <= '0;
      cause    <= '0;
      exl      <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pc_load  <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | cause_req;
      if (mask_we) mask <= mask_in;
      pc_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= FETCH;
            epc      <= epc_in;
            cause    <= DATA_W'(sel);
            exl      <= 1'b1;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= VEC_BASE + (DATA_W'(sel) << 2);
          end
        end
        FETCH: begin
          cnt <= CNT_W'(MEM_LAT - 1);
          if (MEM_LAT == 1) begin
            state   <= LOAD;
            pc_load <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= LOAD;
            pc_load <= 1'b1;
          end
        end
        LOAD: begin
          state    <= HANDLER;
          busy     <= 1'b0;
          mem_req  <= 1'b0;
          mem_addr <= '0;
        end
        HANDLER: begin
          if (eret) begin
            state   <= RETURN;
            busy    <= 1'b1;
            pc_load <= 1'b1;
          end
        end
        RETURN: begin
          state <= IDLE;
          exl   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench: a MEM_LAT=1 and a MEM_LAT=3 instance share stimulus; a vector-table
// memory model and a set-based pending/mask model supply every expected value.
module tb_exception_unit;

  logic        clock;
  logic        reset;
  logic [3:0]  cause_req;
  logic [31:0] epc_in;
  logic        mask_we;
  logic [3:0]  mask_in;
  logic        eret;
  logic [31:0] mem_data1, mem_data3;

  logic        busy1, mem_req1, pc_load1, exl1;
  logic [31:0] mem_addr1, pc_value1, epc1, cause1;
  logic [3:0]  mask1;
  logic        busy3, mem_req3, pc_load3, exl3;
  logic [31:0] mem_addr3, pc_value3, epc3, cause3;
  logic [3:0]  mask3;

  logic [31:0] vec [4];
  logic [31:0] ap1;
  logic [31:0] ap3 [3];

  int checks = 0;
  int failures = 0;

  exception_unit #(.DATA_W(32), .N_CAUSES(4), .VEC_BASE(32'hF0), .MEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .cause_req(cause_req), .epc_in(epc_in),
    .mask_we(mask_we), .mask_in(mask_in), .eret(eret), .mem_data(mem_data1),
    .busy(busy1), .mem_req(mem_req1), .mem_addr(mem_addr1), .pc_load(pc_load1),
    .pc_value(pc_value1), .epc(epc1), .cause(cause1), .exl(exl1), .mask(mask1)
  );

  exception_unit #(.DATA_W(32), .N_CAUSES(4), .VEC_BASE(32'hF0), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .cause_req(cause_req), .epc_in(epc_in),
    .mask_we(mask_we), .mask_in(mask_in), .eret(eret), .mem_data(mem_data3),
    .busy(busy3), .mem_req(mem_req3), .mem_addr(mem_addr3), .pc_load(pc_load3),
    .pc_value(pc_value3), .epc(epc3), .cause(cause3), .exl(exl3), .mask(mask3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] vec_lookup(input logic [31:0] a);
    int k;
    if (a >= 32'hF0 && a < 32'h100 && a[1:0] == 2'b00) begin
      k = int'((a - 32'hF0) >> 2);
      return vec[k];
    end
    return 32'hDEADBEEF;
  endfunction

  // Memory returns the word addressed MEM_LAT cycles earlier.
  always @(posedge clock) begin
    ap1    <= mem_addr1;
    ap3[0] <= mem_addr3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  always_comb mem_data1 = vec_lookup(ap1);
  always_comb mem_data3 = vec_lookup(ap3[2]);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cause_req = '0; epc_in = '0; mask_we = 1'b0; mask_in = '0; eret = 1'b0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic init_vec();
    for (int i = 0; i < 4; i++) vec[i] = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy1, mem_req1, pc_load1, exl1, mask1, mem_addr1, pc_value1, epc1, cause1} !== '0) begin
      failures++; $display("FAIL reset_state dut1 got busy=%0d req=%0d exl=%0d mask=%h epc=%h cause=%h want all 0",
                           busy1, mem_req1, exl1, mask1, epc1, cause1);
    end
    init_vec();
    mask_we = 1'b1; mask_in = 4'b1000; cause_req = 4'b0110; epc_in = 32'h44;
    step();
    mask_we = 1'b0; cause_req = '0;
    step(); step();
    checks++;
    if ({pc_load1, busy3, mem_req3} !== 3'b111) begin
      failures++; $display("FAIL reset_setup got pc_load1=%0d busy3=%0d req3=%0d want 1 1 1", pc_load1, busy3, mem_req3);
    end
    #2; reset = 1'b0; #1;
    checks++;
    if ({busy1, mem_req1, pc_load1, exl1, mask1, mem_addr1, pc_value1, epc1, cause1} !== '0) begin
      failures++; $display("FAIL reset_async dut1 got busy=%0d req=%0d load=%0d exl=%0d epc=%h cause=%h pc=%h want all 0",
                           busy1, mem_req1, pc_load1, exl1, epc1, cause1, pc_value1);
    end
    checks++;
    if ({busy3, mem_req3, pc_load3, exl3, mask3, mem_addr3, pc_value3, epc3, cause3} !== '0) begin
      failures++; $display("FAIL reset_async_wait dut3 got busy=%0d req=%0d addr=%h exl=%0d want all 0",
                           busy3, mem_req3, mem_addr3, exl3);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({busy1, busy3} !== 2'b00) begin
        failures++; $display("FAIL reset_pending_cleared cycle %0d got busy1=%0d busy3=%0d want 0 0", i, busy1, busy3);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    init_vec();
    vec[0] = 32'h200;
    cause_req = 4'b0001; epc_in = 32'h40;
    step();
    cause_req = '0;
    step();
    checks++;
    if ({mem_req1, mem_addr1, busy1, pc_load1} !== {1'b1, 32'hF0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL single_fetch got req=%0d addr=%h busy=%0d load=%0d want 1 f0 1 0",
                           mem_req1, mem_addr1, busy1, pc_load1);
    end
    step();
    checks++;
    if ({pc_load1, pc_value1, epc1, cause1, exl1, mem_req1} !== {1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL single_load got load=%0d pc=%h epc=%h cause=%h exl=%0d want 1 200 40 0 1",
                           pc_load1, pc_value1, epc1, cause1, exl1);
    end
    step();
    checks++;
    if ({busy1, pc_load1, mem_req1, exl1} !== 4'b0001) begin
      failures++; $display("FAIL single_handler got busy=%0d load=%0d req=%0d exl=%0d want 0 0 0 1",
                           busy1, pc_load1, mem_req1, exl1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    init_vec();
    cause_req = 4'b1010; epc_in = 32'h80;
    step();
    cause_req = '0;
    step();
    checks++;
    if ({mem_req1, mem_addr1} !== {1'b1, 32'hF4}) begin
      failures++; $display("FAIL prio_first_addr got req=%0d addr=%h want 1 f4", mem_req1, mem_addr1);
    end
    step();
    checks++;
    if ({pc_load1, pc_value1, cause1} !== {1'b1, vec[1], 32'd1}) begin
      failures++; $display("FAIL prio_first_load got load=%0d pc=%h cause=%0d want 1 %h 1", pc_load1, pc_value1, cause1, vec[1]);
    end
    step();
    eret = 1'b1; epc_in = 32'h99;
    step();
    eret = 1'b0;
    checks++;
    if ({pc_load1, pc_value1} !== {1'b1, 32'h80}) begin
      failures++; $display("FAIL prio_return got load=%0d pc=%h want 1 80", pc_load1, pc_value1);
    end
    step(); step();
    checks++;
    if ({mem_req1, mem_addr1} !== {1'b1, 32'hFC}) begin
      failures++; $display("FAIL prio_second_addr got req=%0d addr=%h want 1 fc", mem_req1, mem_addr1);
    end
    step();
    checks++;
    if ({pc_value1, cause1, epc1} !== {vec[3], 32'd3, 32'h99}) begin
      failures++; $display("FAIL prio_second_load got pc=%h cause=%0d epc=%h want %h 3 99", pc_value1, cause1, epc1, vec[3]);
    end
  endtask

  task automatic test_mask();
    do_reset();
    init_vec();
    mask_we = 1'b1; mask_in = 4'b0100; cause_req = 4'b0100;
    step();
    mask_we = 1'b0; cause_req = '0;
    checks++;
    if (mask1 !== 4'b0100) begin
      failures++; $display("FAIL mask_write got %b want 0100", mask1);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({busy1, mem_req1} !== 2'b00) begin
        failures++; $display("FAIL mask_blocks cycle %0d got busy=%0d req=%0d want 0 0", i, busy1, mem_req1);
      end
    end
    mask_we = 1'b1; mask_in = 4'b0000;
    step();
    mask_we = 1'b0;
    step();
    checks++;
    if ({busy1, mem_req1, mem_addr1, cause1} !== {1'b1, 1'b1, 32'hF8, 32'd2}) begin
      failures++; $display("FAIL mask_release got busy=%0d req=%0d addr=%h cause=%0d want 1 1 f8 2",
                           busy1, mem_req1, mem_addr1, cause1);
    end
  endtask

  task automatic test_latency();
    do_reset();
    init_vec();
    cause_req = 4'b0100; epc_in = 32'h123;
    step();
    cause_req = '0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({mem_req3, mem_addr3, pc_load3, busy3} !== {1'b1, 32'hF8, 1'b0, 1'b1}) begin
        failures++; $display("FAIL lat3_hold cycle %0d got req=%0d addr=%h load=%0d busy=%0d want 1 f8 0 1",
                             k, mem_req3, mem_addr3, pc_load3, busy3);
      end
    end
    step();
    checks++;
    if ({pc_load3, pc_value3, mem_addr3, epc3} !== {1'b1, vec[2], 32'hF8, 32'h123}) begin
      failures++; $display("FAIL lat3_load got load=%0d pc=%h addr=%h epc=%h want 1 %h f8 123",
                           pc_load3, pc_value3, mem_addr3, epc3, vec[2]);
    end
    step();
    checks++;
    if ({pc_load3, busy3} !== 2'b00) begin
      failures++; $display("FAIL lat3_after got load=%0d busy=%0d want 0 0", pc_load3, busy3);
    end
  endtask

  task automatic test_eret();
    do_reset();
    init_vec();
    eret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({pc_load1, busy1, exl1} !== 3'b000) begin
        failures++; $display("FAIL eret_idle cycle %0d got load=%0d busy=%0d exl=%0d want 0 0 0", i, pc_load1, busy1, exl1);
      end
    end
    eret = 1'b0;
    cause_req = 4'b0100; epc_in = 32'h300;
    step();
    cause_req = '0;
    eret = 1'b1;
    step(); step(); step();
    eret = 1'b0;
    step();
    checks++;
    if ({busy1, pc_load1, exl1} !== 3'b001) begin
      failures++; $display("FAIL eret_outside_handler got busy=%0d load=%0d exl=%0d want 0 0 1", busy1, pc_load1, exl1);
    end
    eret = 1'b1; cause_req = 4'b0001; epc_in = 32'h500;
    step();
    eret = 1'b0; cause_req = '0;
    checks++;
    if ({pc_load1, pc_value1, busy1} !== {1'b1, 32'h300, 1'b1}) begin
      failures++; $display("FAIL eret_wins got load=%0d pc=%h busy=%0d want 1 300 1", pc_load1, pc_value1, busy1);
    end
    step();
    checks++;
    if ({busy1, exl1, pc_load1} !== 3'b000) begin
      failures++; $display("FAIL eret_idle_after got busy=%0d exl=%0d load=%0d want 0 0 0", busy1, exl1, pc_load1);
    end
    step();
    checks++;
    if ({mem_req1, mem_addr1, cause1, epc1} !== {1'b1, 32'hF0, 32'd0, 32'h500}) begin
      failures++; $display("FAIL eret_then_fetch got req=%0d addr=%h cause=%0d epc=%h want 1 f0 0 500",
                           mem_req1, mem_addr1, cause1, epc1);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pend, mk, r;
    logic [31:0] e, e2;
    int          sel;
    do_reset();
    init_vec();
    pend = '0;
    for (int round = 0; round < 25; round++) begin
      r  = 4'($urandom_range(1, 15));
      mk = (round == 24) ? 4'b0000 : 4'($urandom_range(0, 15));
      e  = $urandom;
      mask_we = 1'b1; mask_in = mk; cause_req = r; epc_in = e;
      step();
      mask_we = 1'b0; cause_req = '0;
      pend = pend | r;
      checks++;
      if (mask1 !== mk) begin
        failures++; $display("FAIL rand_mask round %0d got %b want %b", round, mask1, mk);
      end
      for (int it = 0; it < 5; it++) begin
        sel = -1;
        for (int i = 3; i >= 0; i--) if (pend[i] && !mk[i]) sel = i;
        if (sel < 0) begin
          step();
          checks++;
          if (busy1 !== 1'b0) begin
            failures++; $display("FAIL rand_idle round %0d got busy=%0d want 0", round, busy1);
          end
          break;
        end
        step();
        checks++;
        if ({mem_req1, mem_addr1} !== {1'b1, 32'hF0 + 32'(4 * sel)}) begin
          failures++; $display("FAIL rand_fetch round %0d got req=%0d addr=%h want 1 %h",
                               round, mem_req1, mem_addr1, 32'hF0 + 32'(4 * sel));
        end
        step();
        checks++;
        if ({pc_load1, pc_value1, cause1, epc1} !== {1'b1, vec[sel], 32'(sel), e}) begin
          failures++; $display("FAIL rand_load round %0d got load=%0d pc=%h cause=%0d epc=%h want 1 %h %0d %h",
                               round, pc_load1, pc_value1, cause1, epc1, vec[sel], sel, e);
        end
        pend[sel] = 1'b0;
        step();
        e2 = $urandom;
        eret = 1'b1; epc_in = e2;
        step();
        eret = 1'b0;
        checks++;
        if ({pc_load1, pc_value1} !== {1'b1, e}) begin
          failures++; $display("FAIL rand_return round %0d got load=%0d pc=%h want 1 %h", round, pc_load1, pc_value1, e);
        end
        e = e2;
        step();
        checks++;
        if ({busy1, exl1} !== 2'b00) begin
          failures++; $display("FAIL rand_back_idle round %0d got busy=%0d exl=%0d want 0 0", round, busy1, exl1);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cause_req = '0; epc_in = '0; mask_we = 1'b0; mask_in = '0; eret = 1'b0;
    for (int i = 0; i < 4; i++) vec[i] = '0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_latency();
    test_eret();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
